// File: rtl/qsys_rgb_fade_source_if.sv
// Bundle of the Avalon-MM control port and the Avalon-ST colour output of
// qsys_rgb_fade_source. The slave modport is the colour source's view; the
// master modport is the view of the CPU bridge / downstream sink side.
interface qsys_rgb_fade_source_if;
    logic [1:0]  avs_CTRL_address;
    logic [31:0] avs_CTRL_writedata;
    logic [31:0] avs_CTRL_readdata;
    logic [3:0]  avs_CTRL_byteenable;
    logic        avs_CTRL_write;
    logic        avs_CTRL_read;
    logic        avs_CTRL_waitrequest;
    logic [23:0] aso_RGB_data;
    logic        aso_RGB_valid;
    logic        aso_RGB_ready;

    modport slave (
        input  avs_CTRL_address,
        input  avs_CTRL_writedata,
        output avs_CTRL_readdata,
        input  avs_CTRL_byteenable,
        input  avs_CTRL_write,
        input  avs_CTRL_read,
        output avs_CTRL_waitrequest,
        output aso_RGB_data,
        output aso_RGB_valid,
        input  aso_RGB_ready
    );

    modport master (
        output avs_CTRL_address,
        output avs_CTRL_writedata,
        input  avs_CTRL_readdata,
        output avs_CTRL_byteenable,
        output avs_CTRL_write,
        output avs_CTRL_read,
        input  avs_CTRL_waitrequest,
        input  aso_RGB_data,
        input  aso_RGB_valid,
        output aso_RGB_ready
    );
endinterface

// File: rtl/qsys_rgb_fade_source.sv
// Avalon-ST colour source that ramps a current {R,G,B} colour one code per
// channel per step toward a software-written target, emitting each new
// colour as one backpressured beat. Step spacing is set by a divider.
module qsys_rgb_fade_source (
    input  logic                          csi_MCLK_clk,
    input  logic                          rsi_MRST_reset,
    qsys_rgb_fade_source_if.slave         bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_EMIT  = 2'd2
    } state_e;

    // Byte-lane write merge: keep the old byte unless its enable is set.
    function automatic logic [7:0] merge8(input logic [7:0] old_v,
                                          input logic [7:0] new_v,
                                          input logic       en);
        return en ? new_v : old_v;
    endfunction

    // One-code move of a channel toward its target; never wraps because
    // the direction always follows the comparison.
    function automatic logic [7:0] step_chan(input logic [7:0] cur,
                                             input logic [7:0] tgt);
        logic [7:0] r;
        if (cur < tgt) begin
            r = cur + 8'd1;
        end else if (cur > tgt) begin
            r = cur - 8'd1;
        end else begin
            r = cur;
        end
        return r;
    endfunction

    function automatic logic [23:0] step_colour(input logic [23:0] cur,
                                                input logic [23:0] tgt);
        return {step_chan(cur[23:16], tgt[23:16]),
                step_chan(cur[15:8],  tgt[15:8]),
                step_chan(cur[7:0],   tgt[7:0])};
    endfunction

    state_e      state_q, state_d;
    logic        run_q, run_d;
    logic [23:0] target_q, target_d;
    logic [15:0] div_q, div_d;
    logic [23:0] current_q, current_d;
    logic [15:0] cnt_q, cnt_d;
    logic [23:0] data_q, data_d;
    logic        valid_q, valid_d;

    logic        wr_ctrl_s, wr_tgt_s, wr_div_s, wr_cur_s;
    logic [23:0] tgt_wr_val_s, cur_wr_val_s, step_val_s;
    logic [15:0] div_wr_val_s;
    logic        accept_s;
    logic        unused_inputs_s;

    assign wr_ctrl_s = bus.avs_CTRL_write && (bus.avs_CTRL_address == 2'd0);
    assign wr_tgt_s  = bus.avs_CTRL_write && (bus.avs_CTRL_address == 2'd1);
    assign wr_div_s  = bus.avs_CTRL_write && (bus.avs_CTRL_address == 2'd2);
    assign wr_cur_s  = bus.avs_CTRL_write && (bus.avs_CTRL_address == 2'd3);

    assign tgt_wr_val_s = {merge8(target_q[23:16],  bus.avs_CTRL_writedata[23:16], bus.avs_CTRL_byteenable[2]),
                           merge8(target_q[15:8],   bus.avs_CTRL_writedata[15:8],  bus.avs_CTRL_byteenable[1]),
                           merge8(target_q[7:0],    bus.avs_CTRL_writedata[7:0],   bus.avs_CTRL_byteenable[0])};
    assign cur_wr_val_s = {merge8(current_q[23:16], bus.avs_CTRL_writedata[23:16], bus.avs_CTRL_byteenable[2]),
                           merge8(current_q[15:8],  bus.avs_CTRL_writedata[15:8],  bus.avs_CTRL_byteenable[1]),
                           merge8(current_q[7:0],   bus.avs_CTRL_writedata[7:0],   bus.avs_CTRL_byteenable[0])};
    assign div_wr_val_s = {merge8(div_q[15:8], bus.avs_CTRL_writedata[15:8], bus.avs_CTRL_byteenable[1]),
                           merge8(div_q[7:0],  bus.avs_CTRL_writedata[7:0],  bus.avs_CTRL_byteenable[0])};
    assign step_val_s   = step_colour(current_q, target_q);
    assign accept_s     = valid_q && bus.aso_RGB_ready;

    // Reads have no side effects and the top byte lanes carry nothing.
    assign unused_inputs_s = ^{bus.avs_CTRL_read, bus.avs_CTRL_writedata[31:24],
                               bus.avs_CTRL_byteenable[3]};

    assign bus.avs_CTRL_waitrequest = rsi_MRST_reset;
    assign bus.aso_RGB_data         = data_q;
    assign bus.aso_RGB_valid        = valid_q;

    // State and register file; reset may arrive at any point mid-fade.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            state_q   <= ST_IDLE;
            run_q     <= 1'b0;
            target_q  <= 24'd0;
            div_q     <= 16'd0;
            current_q <= 24'd0;
            cnt_q     <= 16'd0;
            data_q    <= 24'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            target_q  <= target_d;
            div_q     <= div_d;
            current_q <= current_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    // Register writes plus the IDLE/COUNT/EMIT sequencing of the fade.
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        target_d  = target_q;
        div_d     = div_q;
        current_d = current_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;

        if (wr_ctrl_s && bus.avs_CTRL_byteenable[0]) begin
            run_d = bus.avs_CTRL_writedata[0];
        end else begin
            run_d = run_q;
        end
        if (wr_tgt_s) begin
            target_d = tgt_wr_val_s;
        end else begin
            target_d = target_q;
        end
        if (wr_div_s) begin
            div_d = div_wr_val_s;
        end else begin
            div_d = div_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_cur_s) begin
                    current_d = cur_wr_val_s;
                    data_d    = cur_wr_val_s;
                    valid_d   = 1'b1;
                    state_d   = ST_EMIT;
                end else if (run_q && (current_q != target_q)) begin
                    cnt_d   = div_q;
                    state_d = ST_COUNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                // A CURRENT write outranks both stopping and stepping.
                if (wr_cur_s) begin
                    current_d = cur_wr_val_s;
                    data_d    = cur_wr_val_s;
                    valid_d   = 1'b1;
                    state_d   = ST_EMIT;
                end else if (!run_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    current_d = step_val_s;
                    data_d    = step_val_s;
                    valid_d   = 1'b1;
                    state_d   = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // The pending beat is always delivered, even after run clears.
                if (accept_s) begin
                    valid_d = 1'b0;
                    if (run_q && (current_q != target_q)) begin
                        cnt_d   = div_q;
                        state_d = ST_COUNT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Combinational register read-back.
    always_comb begin
        bus.avs_CTRL_readdata = 32'd0;
        case (bus.avs_CTRL_address)
            2'd0:    bus.avs_CTRL_readdata = {(state_q != ST_IDLE), 30'd0, run_q};
            2'd1:    bus.avs_CTRL_readdata = {8'd0, target_q};
            2'd2:    bus.avs_CTRL_readdata = {16'd0, div_q};
            2'd3:    bus.avs_CTRL_readdata = {8'd0, current_q};
            default: bus.avs_CTRL_readdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_qsys_rgb_fade_source.sv
// Directed and randomized checks of qsys_rgb_fade_source against a
// per-channel arithmetic model of the fade sequence.
module tb_qsys_rgb_fade_source;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [23:0] got[$];
    logic [23:0] exp_q[$];
    logic        stall_pend = 1'b0;
    logic [23:0] held = 24'd0;

    qsys_rgb_fade_source_if bus();

    qsys_rgb_fade_source dut (
        .csi_MCLK_clk   (clk),
        .rsi_MRST_reset (rst),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sink monitor: record accepted beats, verify stalled beats stay put.
    always @(negedge clk) begin
        if (rst) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("hold_valid", {31'd0, bus.aso_RGB_valid}, 32'd1);
                check("hold_data", {8'd0, bus.aso_RGB_data}, {8'd0, held});
            end
            if (bus.aso_RGB_valid && bus.aso_RGB_ready) got.push_back(bus.aso_RGB_data);
            stall_pend = bus.aso_RGB_valid && !bus.aso_RGB_ready;
            held       = bus.aso_RGB_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mm_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.avs_CTRL_address    = a;
        bus.avs_CTRL_writedata  = d;
        bus.avs_CTRL_byteenable = be;
        bus.avs_CTRL_write      = 1'b1;
        tick();
        bus.avs_CTRL_write      = 1'b0;
    endtask

    task automatic mm_check(input logic [1:0] a, input logic [31:0] exp, input string tag);
        bus.avs_CTRL_address = a;
        bus.avs_CTRL_read    = 1'b1;
        #1;
        check(tag, bus.avs_CTRL_readdata, exp);
        bus.avs_CTRL_read    = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.aso_RGB_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_wait"}, {31'd0, bus.aso_RGB_valid}, 32'd1);
    endtask

    // Reference: beat k moves each channel min(k, distance) codes toward target.
    function automatic void fill_expected(input logic [23:0] cur, input logic [23:0] tgt);
        int c[3], t[3], d[3], n, v;
        logic [23:0] beat;
        exp_q.delete();
        n = 0;
        for (int i = 0; i < 3; i++) begin
            c[i] = int'(cur[i*8 +: 8]);
            t[i] = int'(tgt[i*8 +: 8]);
            d[i] = (t[i] > c[i]) ? t[i] - c[i] : c[i] - t[i];
            if (d[i] > n) n = d[i];
        end
        for (int k = 1; k <= n; k++) begin
            for (int i = 0; i < 3; i++) begin
                v = (t[i] >= c[i]) ? c[i] + ((k < d[i]) ? k : d[i])
                                   : c[i] - ((k < d[i]) ? k : d[i]);
                beat[i*8 +: 8] = 8'(v);
            end
            exp_q.push_back(beat);
        end
    endfunction

    // Stop any fade, load CURRENT (which emits one beat), then flush records.
    task automatic prep_current(input logic [23:0] c);
        bus.aso_RGB_ready = 1'b1;
        mm_write(2'd0, 32'd0, 4'hF);
        repeat (3) tick();
        mm_write(2'd3, {8'd0, c}, 4'hF);
        repeat (3) tick();
        got.delete();
    endtask

    // mode 0: ready held 1; mode 1: random ready; mode 2: one 10-cycle stall.
    task automatic fade(input logic [23:0] cur, input logic [23:0] tgt, input logic [15:0] dv,
                        input int mode, input string tag);
        int  n = 0;
        bit  stalled = 1'b0;
        prep_current(cur);
        fill_expected(cur, tgt);
        mm_write(2'd2, {16'd0, dv}, 4'hF);
        mm_write(2'd1, {8'd0, tgt}, 4'hF);
        mm_write(2'd0, 32'd1, 4'hF);
        while (got.size() < exp_q.size() && n < 20000) begin
            if (mode == 1) begin
                bus.aso_RGB_ready = ($urandom_range(0, 3) != 0);
            end else if (mode == 2 && !stalled && bus.aso_RGB_valid) begin
                bus.aso_RGB_ready = 1'b0;
                repeat (10) tick();
                n += 10;
                bus.aso_RGB_ready = 1'b1;
                stalled = 1'b1;
            end
            tick();
            n++;
        end
        bus.aso_RGB_ready = 1'b1;
        repeat (4) tick();
        check({tag, "_beats"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check($sformatf("%s_beat%0d", tag, i), {8'd0, got[i]}, {8'd0, exp_q[i]});
        end
        mm_check(2'd0, 32'h0000_0001, {tag, "_idle"});
        mm_write(2'd0, 32'd0, 4'hF);
    endtask

    initial begin
        logic        exp_v;
        logic [7:0]  r;
        logic [23:0] cur, tgt;
        int          ch;

        rst = 1'b1;
        bus.avs_CTRL_address    = 2'd0;
        bus.avs_CTRL_writedata  = 32'd0;
        bus.avs_CTRL_byteenable = 4'h0;
        bus.avs_CTRL_write      = 1'b0;
        bus.avs_CTRL_read       = 1'b0;
        bus.aso_RGB_ready       = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_waitreq", {31'd0, bus.avs_CTRL_waitrequest}, 32'd1);
        check("rst_valid", {31'd0, bus.aso_RGB_valid}, 32'd0);
        check("rst_data", {8'd0, bus.aso_RGB_data}, 32'd0);
        rst = 1'b0;
        #1;
        check("run_waitreq", {31'd0, bus.avs_CTRL_waitrequest}, 32'd0);
        for (int a = 0; a < 4; a++) mm_check(2'(a), 32'd0, $sformatf("rst_reg%0d", a));

        // Byte enables
        mm_write(2'd1, 32'h00AA_BBCC, 4'b0101);
        mm_check(2'd1, 32'h00AA_00CC, "be_target");
        mm_write(2'd2, 32'h0000_1234, 4'b0010);
        mm_check(2'd2, 32'h0000_1200, "be_div");
        mm_write(2'd0, 32'd1, 4'b0000);
        mm_check(2'd0, 32'd0, "be_ctrl");
        got.delete();
        mm_write(2'd3, 32'h0011_2233, 4'b0001);
        check("cur_wr_valid", {31'd0, bus.aso_RGB_valid}, 32'd1);
        check("cur_wr_data", {8'd0, bus.aso_RGB_data}, 32'h0000_0033);
        repeat (3) tick();
        mm_check(2'd3, 32'h0000_0033, "be_current");

        // Basic fade, DIV=0: beats at edges 2, 4, 6 after the run write
        prep_current(24'h000000);
        mm_write(2'd2, 32'd0, 4'hF);
        mm_write(2'd1, 32'h0003_0100, 4'hF);
        mm_write(2'd0, 32'd1, 4'hF);
        for (int t = 1; t <= 8; t++) begin
            tick();
            exp_v = (t == 2 || t == 4 || t == 6);
            r     = 8'(t / 2);
            check($sformatf("basic_valid_t%0d", t), {31'd0, bus.aso_RGB_valid}, {31'd0, exp_v});
            if (exp_v) check($sformatf("basic_data_t%0d", t), {8'd0, bus.aso_RGB_data}, {8'd0, r, 8'h01, 8'h00});
            if (t == 1) mm_check(2'd0, 32'h8000_0001, "basic_busy");
        end
        mm_check(2'd0, 32'h0000_0001, "basic_done");
        mm_write(2'd0, 32'd0, 4'hF);

        // Divider D=4: valid at edges 6 and 12
        prep_current(24'h000000);
        mm_write(2'd2, 32'd4, 4'hF);
        mm_write(2'd1, 32'h0000_0002, 4'hF);
        mm_write(2'd0, 32'd1, 4'hF);
        for (int t = 1; t <= 14; t++) begin
            tick();
            exp_v = (t == 6 || t == 12);
            check($sformatf("div_valid_t%0d", t), {31'd0, bus.aso_RGB_valid}, {31'd0, exp_v});
            if (exp_v) check($sformatf("div_data_t%0d", t), {8'd0, bus.aso_RGB_data}, (t == 6) ? 32'd1 : 32'd2);
        end
        mm_write(2'd0, 32'd0, 4'hF);

        // Backpressure across a full 255-beat fade
        fade(24'h000000, 24'hFF0000, 16'd0, 2, "bp");

        // Downward and mixed directions
        fade(24'h0A0005, 24'h08FF05, 16'd0, 0, "mixed");

        // Random fades with random ready
        for (int it = 0; it < 4; it++) begin
            cur = 24'($urandom());
            for (int i = 0; i < 3; i++) begin
                ch = int'(cur[i*8 +: 8]) + int'($urandom_range(0, 40)) - 20;
                if (ch < 0) ch = 0;
                if (ch > 255) ch = 255;
                tgt[i*8 +: 8] = 8'(ch);
            end
            fade(cur, tgt, 16'($urandom_range(0, 3)), 1, $sformatf("rand%0d", it));
        end

        // run cleared mid-COUNT
        prep_current(24'h000000);
        mm_write(2'd2, 32'd20, 4'hF);
        mm_write(2'd1, 32'h0000_0005, 4'hF);
        mm_write(2'd0, 32'd1, 4'hF);
        repeat (5) tick();
        mm_write(2'd0, 32'd0, 4'hF);
        mm_check(2'd0, 32'h8000_0000, "stop_count_busy");
        tick();
        mm_check(2'd0, 32'h0000_0000, "stop_count_idle");
        repeat (40) tick();
        check("stop_count_nobeat", got.size(), 32'd0);

        // run cleared during a stalled EMIT
        prep_current(24'h000000);
        mm_write(2'd2, 32'd0, 4'hF);
        mm_write(2'd1, 32'h0000_0003, 4'hF);
        bus.aso_RGB_ready = 1'b0;
        mm_write(2'd0, 32'd1, 4'hF);
        wait_valid("stop_emit");
        mm_write(2'd0, 32'd0, 4'hF);
        repeat (3) tick();
        check("stop_emit_valid", {31'd0, bus.aso_RGB_valid}, 32'd1);
        check("stop_emit_data", {8'd0, bus.aso_RGB_data}, 32'd1);
        bus.aso_RGB_ready = 1'b1;
        tick();
        check("stop_emit_drop", {31'd0, bus.aso_RGB_valid}, 32'd0);
        mm_check(2'd0, 32'h0000_0000, "stop_emit_idle");
        repeat (10) tick();
        check("stop_emit_count", got.size(), 32'd1);
        if (got.size() > 0) check("stop_emit_beat", {8'd0, got[0]}, 32'd1);

        // Async reset mid-EMIT
        prep_current(24'h000000);
        mm_write(2'd2, 32'd0, 4'hF);
        mm_write(2'd1, 32'h0000_0005, 4'hF);
        bus.aso_RGB_ready = 1'b0;
        mm_write(2'd0, 32'd1, 4'hF);
        wait_valid("arst");
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, bus.aso_RGB_valid}, 32'd0);
        check("arst_data", {8'd0, bus.aso_RGB_data}, 32'd0);
        check("arst_waitreq", {31'd0, bus.avs_CTRL_waitrequest}, 32'd1);
        repeat (3) tick();
        check("arst_waitreq_held", {31'd0, bus.avs_CTRL_waitrequest}, 32'd1);
        rst = 1'b0;
        bus.aso_RGB_ready = 1'b1;
        #1;
        check("arst_release", {31'd0, bus.avs_CTRL_waitrequest}, 32'd0);
        for (int a = 0; a < 4; a++) mm_check(2'(a), 32'd0, $sformatf("arst_reg%0d", a));
        repeat (5) tick();
        check("arst_no_valid", {31'd0, bus.aso_RGB_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
